// File: rtl/vga_pkg.sv
// Shared timing constants, mode encodings and pipeline payload for the VGA pixel engine.
package vga_pkg;

    localparam int unsigned H_ACTIVE = 640;
    localparam int unsigned H_FP     = 16;
    localparam int unsigned H_SYNC   = 96;
    localparam int unsigned H_BP     = 48;
    localparam int unsigned V_ACTIVE = 480;
    localparam int unsigned V_FP     = 10;
    localparam int unsigned V_SYNC   = 2;
    localparam int unsigned V_BP     = 33;

    localparam int unsigned CNT_W = 10;  // raster x/y counter width
    localparam int unsigned D_W   = 11;  // signed offset from centre
    localparam int unsigned D2_W  = 22;  // squared distance
    localparam int unsigned RAD_W = 9;
    localparam int unsigned R2_W  = 18;

    typedef enum logic [1:0] {
        MODE_SOLID    = 2'd0,
        MODE_XOR_CIRC = 2'd1,
        MODE_XOR_FULL = 2'd2,
        MODE_BARS     = 2'd3
    } mode_e;

    // First pipeline stage payload
    typedef struct packed {
        logic [D_W-1:0]   dx;
        logic [D_W-1:0]   dy;
        logic [CNT_W-1:0] mx;
        logic [CNT_W-1:0] my;
        logic [2:0]       bar;
        logic             active;
        logic             hs;
        logic             vs;
    } s1_t;

endpackage

// File: rtl/vga_timing.sv
// Raster counters with sync/active decodes and a registered frame-boundary tick.
module vga_timing #(
    parameter int unsigned H_ACTIVE = vga_pkg::H_ACTIVE,
    parameter int unsigned H_FP     = vga_pkg::H_FP,
    parameter int unsigned H_SYNC   = vga_pkg::H_SYNC,
    parameter int unsigned H_BP     = vga_pkg::H_BP,
    parameter int unsigned V_ACTIVE = vga_pkg::V_ACTIVE,
    parameter int unsigned V_FP     = vga_pkg::V_FP,
    parameter int unsigned V_SYNC   = vga_pkg::V_SYNC,
    parameter int unsigned V_BP     = vga_pkg::V_BP
) (
    input  logic                      clk,
    input  logic                      rst_n,
    output logic [vga_pkg::CNT_W-1:0] x,
    output logic [vga_pkg::CNT_W-1:0] y,
    output logic                      hs_raw_c,
    output logic                      vs_raw_c,
    output logic                      active_c,
    output logic                      frame_tick
);
    import vga_pkg::*;

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    logic [CNT_W-1:0] x_nxt;
    logic [CNT_W-1:0] y_nxt;

    // Next raster position: x wraps every line, y advances on x wrap
    always_comb begin
        x_nxt = x + CNT_W'(1);
        y_nxt = y;
        if (x == CNT_W'(H_TOTAL - 1)) begin
            x_nxt = '0;
            y_nxt = (y == CNT_W'(V_TOTAL - 1)) ? '0 : y + CNT_W'(1);
        end
    end

    // Counter registers; tick is high exactly while the counters read (0, V_ACTIVE)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x          <= '0;
            y          <= '0;
            frame_tick <= 1'b0;
        end else begin
            x          <= x_nxt;
            y          <= y_nxt;
            frame_tick <= (x_nxt == '0) && (y_nxt == CNT_W'(V_ACTIVE));
        end
    end

    assign hs_raw_c = !((x >= CNT_W'(H_ACTIVE + H_FP)) && (x < CNT_W'(H_ACTIVE + H_FP + H_SYNC)));
    assign vs_raw_c = !((y >= CNT_W'(V_ACTIVE + V_FP)) && (y < CNT_W'(V_ACTIVE + V_FP + V_SYNC)));
    assign active_c = (x < CNT_W'(H_ACTIVE)) && (y < CNT_W'(V_ACTIVE));

endmodule

// File: rtl/vga_shape_pattern_gen.sv
// VGA pixel engine: raster timing, frame-latched controls, animation counter and
// a two-stage circle/pattern colour pipeline with syncs delayed to match.
module vga_shape_pattern_gen #(
    parameter int unsigned H_ACTIVE   = vga_pkg::H_ACTIVE,
    parameter int unsigned H_FP       = vga_pkg::H_FP,
    parameter int unsigned H_SYNC     = vga_pkg::H_SYNC,
    parameter int unsigned H_BP       = vga_pkg::H_BP,
    parameter int unsigned V_ACTIVE   = vga_pkg::V_ACTIVE,
    parameter int unsigned V_FP       = vga_pkg::V_FP,
    parameter int unsigned V_SYNC     = vga_pkg::V_SYNC,
    parameter int unsigned V_BP       = vga_pkg::V_BP,
    parameter int unsigned COLOR_BITS = 2,
    parameter int unsigned CX         = 320,
    parameter int unsigned CY         = 240,
    parameter int unsigned FCNT_W     = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            mode,
    input  logic [8:0]            radius,
    input  logic                  pause,
    output logic                  hsync,
    output logic                  vsync,
    output logic [COLOR_BITS-1:0] r,
    output logic [COLOR_BITS-1:0] g,
    output logic [COLOR_BITS-1:0] b,
    output logic                  frame_tick,
    output logic [FCNT_W-1:0]     frame_cnt
);
    import vga_pkg::*;

    localparam int unsigned CB = COLOR_BITS;

    logic [CNT_W-1:0] x;
    logic [CNT_W-1:0] y;
    logic             hs_raw_c;
    logic             vs_raw_c;
    logic             active_c;

    vga_timing #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_timing (
        .clk        (clk),
        .rst_n      (rst_n),
        .x          (x),
        .y          (y),
        .hs_raw_c   (hs_raw_c),
        .vs_raw_c   (vs_raw_c),
        .active_c   (active_c),
        .frame_tick (frame_tick)
    );

    mode_e           mode_q;
    logic [R2_W-1:0] r2_q;
    logic [R2_W-1:0] rad_w;
    logic [R2_W-1:0] r2_c;

    assign rad_w = R2_W'(radius);
    assign r2_c  = rad_w * rad_w;

    // Controls and animation step only at the frame boundary, so a frame never tears
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q    <= MODE_SOLID;
            r2_q      <= '0;
            frame_cnt <= '0;
        end else if (frame_tick) begin
            mode_q <= mode_e'(mode);
            r2_q   <= r2_c;
            if (!pause) begin
                frame_cnt <= frame_cnt + FCNT_W'(1);
            end
        end
    end

    s1_t s1_c;
    s1_t s1_q;

    // Stage 1 inputs: centre offsets, animated coordinates, bar index and raw syncs
    always_comb begin
        s1_c        = '0;
        s1_c.dx     = D_W'(x) - D_W'(CX);
        s1_c.dy     = D_W'(y) - D_W'(CY);
        s1_c.mx     = x + CNT_W'(frame_cnt);
        s1_c.my     = y + CNT_W'(frame_cnt >> 2);
        s1_c.bar    = x[CNT_W-1 -: 3];
        s1_c.active = active_c;
        s1_c.hs     = hs_raw_c;
        s1_c.vs     = vs_raw_c;
    end

    // Stage 1 register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= '0;
        end else begin
            s1_q <= s1_c;
        end
    end

    logic signed [D2_W-1:0] dx_w;
    logic signed [D2_W-1:0] dy_w;
    logic signed [D2_W-1:0] sq_x;
    logic signed [D2_W-1:0] sq_y;
    logic [D2_W-1:0]        d2_c;
    logic                   in_c;
    logic [CNT_W-1:0]       c_c;
    logic [CB-1:0]          xor_r;
    logic [CB-1:0]          xor_g;
    logic [CB-1:0]          xor_b;
    logic [CB-1:0]          r_c;
    logic [CB-1:0]          g_c;
    logic [CB-1:0]          b_c;

    assign dx_w = D2_W'($signed(s1_q.dx));
    assign dy_w = D2_W'($signed(s1_q.dy));
    assign sq_x = dx_w * dx_w;
    assign sq_y = dy_w * dy_w;
    assign d2_c = $unsigned(sq_x) + $unsigned(sq_y);
    assign in_c = (d2_c <= D2_W'(r2_q));
    assign c_c  = s1_q.mx ^ s1_q.my;

    // Stage 2 colour select; the 2-bit blue field carries the raw mx/my bit-4 pair
    always_comb begin
        xor_r = c_c[4 +: CB];
        xor_g = c_c[6 +: CB];
        xor_b = (CB == 2) ? CB'({s1_q.mx[4], s1_q.my[4]}) : c_c[2 +: CB];
        r_c   = '0;
        g_c   = '0;
        b_c   = '0;
        if (s1_q.active) begin
            case (mode_q)
                MODE_SOLID: begin
                    if (in_c) begin
                        r_c = '1;
                        g_c = '1;
                        b_c = '1;
                    end
                end
                MODE_XOR_CIRC: begin
                    if (in_c) begin
                        r_c = xor_r;
                        g_c = xor_g;
                        b_c = xor_b;
                    end
                end
                MODE_XOR_FULL: begin
                    r_c = xor_r;
                    g_c = xor_g;
                    b_c = xor_b;
                end
                MODE_BARS: begin
                    r_c = {CB{s1_q.bar[0]}};
                    g_c = {CB{s1_q.bar[1]}};
                    b_c = {CB{s1_q.bar[2]}};
                end
                default: begin
                    r_c = '0;
                end
            endcase
        end
    end

    // Stage 2 register: colour and syncs leave together
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hsync <= 1'b1;
            vsync <= 1'b1;
            r     <= '0;
            g     <= '0;
            b     <= '0;
        end else begin
            hsync <= s1_q.hs;
            vsync <= s1_q.vs;
            r     <= r_c;
            g     <= g_c;
            b     <= b_c;
        end
    end

endmodule

// File: tb/tb_vga_shape_pattern_gen.sv
// Scoreboard bench for vga_shape_pattern_gen: full-width lines, short frames
// (4 visible lines, 8 total) and a 2-bit frame counter so wrap and pause fit the run.
module tb_vga_shape_pattern_gen;

    localparam int LINE  = 800;
    localparam int FRAME = LINE * 8;
    localparam int TICK  = LINE * 4;
    localparam int K_RGB = 0;
    localparam int K_HS  = 1;
    localparam int K_VS  = 2;
    localparam int K_TCK = 3;
    localparam int K_CNT = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] mode = 2'd0;
    logic [8:0] radius = 9'd200;
    logic       pause = 1'b0;
    logic       hsync;
    logic       vsync;
    logic [1:0] r;
    logic [1:0] g;
    logic [1:0] b;
    logic       frame_tick;
    logic [1:0] frame_cnt;

    vga_shape_pattern_gen #(
        .H_ACTIVE   (640),
        .H_FP       (16),
        .H_SYNC     (96),
        .H_BP       (48),
        .V_ACTIVE   (4),
        .V_FP       (1),
        .V_SYNC     (2),
        .V_BP       (1),
        .COLOR_BITS (2),
        .CX         (320),
        .CY         (2),
        .FCNT_W     (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mode       (mode),
        .radius     (radius),
        .pause      (pause),
        .hsync      (hsync),
        .vsync      (vsync),
        .r          (r),
        .g          (g),
        .b          (b),
        .frame_tick (frame_tick),
        .frame_cnt  (frame_cnt)
    );

    always #5 clk = ~clk;

    // Clock edges since the last reset release
    int cyc;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    typedef struct {
        int    cyc;
        int    kind;
        int    val;
        string name;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, expv, cyc);
        end
    endfunction

    function automatic void sb_push(input int c, input int kind, input int v, input string name);
        exp_t e;
        int   i;
        e.cyc  = c;
        e.kind = kind;
        e.val  = v;
        e.name = name;
        i = 0;
        while (i < sb.size() && sb[i].cyc <= c) i++;
        sb.insert(i, e);
    endfunction

    // Pin cycle for pixel (x,y) of frame f, and counter-domain cycle
    function automatic int pix(input int f, input int x, input int y);
        return f * FRAME + y * LINE + x + 2;
    endfunction
    function automatic int cnt(input int f, input int x, input int y);
        return f * FRAME + y * LINE + x;
    endfunction

    function automatic logic [31:0] get_act(input int kind);
        case (kind)
            K_RGB:   return 32'({r, g, b});
            K_HS:    return 32'(hsync);
            K_VS:    return 32'(vsync);
            K_TCK:   return 32'(frame_tick);
            default: return 32'(frame_cnt);
        endcase
    endfunction

    // Monitor: pop every expectation due at this cycle and compare
    exp_t mon_e;
    always @(negedge clk) begin
        if (rst_n) begin
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                mon_e = sb.pop_front();
                if (mon_e.cyc < cyc) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL %s: missed at cyc %0d (due %0d)", mon_e.name, cyc, mon_e.cyc);
                end else begin
                    check(mon_e.name, get_act(mon_e.kind), 32'(mon_e.val));
                end
            end
        end
    end

    task automatic wait_cyc(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_session1();
        // line timing
        sb_push(657, K_HS, 1, "hs_before_fall");
        sb_push(658, K_HS, 0, "hs_first_fall");
        sb_push(753, K_HS, 0, "hs_last_low");
        sb_push(754, K_HS, 1, "hs_rise");
        sb_push(1457, K_HS, 1, "hs_line2_before");
        sb_push(1458, K_HS, 0, "hs_line2_fall");
        // frame timing
        sb_push(4001, K_VS, 1, "vs_before_fall");
        sb_push(4002, K_VS, 0, "vs_fall");
        sb_push(5601, K_VS, 0, "vs_last_low");
        sb_push(5602, K_VS, 1, "vs_rise");
        sb_push(FRAME + 4002, K_VS, 0, "vs_frame1_fall");
        sb_push(TICK - 1, K_TCK, 0, "tick_before");
        sb_push(TICK, K_TCK, 1, "tick_f0");
        sb_push(TICK + 1, K_TCK, 0, "tick_after");
        sb_push(FRAME + TICK, K_TCK, 1, "tick_f1");
        sb_push(TICK, K_CNT, 0, "fcnt_at_tick");
        sb_push(TICK + 1, K_CNT, 1, "fcnt_0_to_1");
        sb_push(FRAME + TICK + 1, K_CNT, 2, "fcnt_2");
        sb_push(2 * FRAME + TICK + 1, K_CNT, 3, "fcnt_3");
        sb_push(3 * FRAME + TICK, K_CNT, 3, "fcnt_pre_wrap");
        sb_push(3 * FRAME + TICK + 1, K_CNT, 0, "fcnt_wrap");
        // frame 0: reset radius is 0, only the centre pixel
        sb_push(pix(0, 320, 2), K_RGB, 'h3F, "f0_centre");
        sb_push(pix(0, 321, 2), K_RGB, 0, "f0_right_of_centre");
        sb_push(pix(0, 319, 2), K_RGB, 0, "f0_left_of_centre");
        // frame 1: solid circle r=200, mode switched to bars mid-frame without effect
        sb_push(pix(1, 0, 0), K_RGB, 0, "f1_origin");
        sb_push(pix(1, 119, 2), K_RGB, 0, "f1_x119");
        sb_push(pix(1, 120, 2), K_RGB, 'h3F, "f1_x120_edge");
        sb_push(pix(1, 320, 2), K_RGB, 'h3F, "f1_centre");
        sb_push(pix(1, 520, 2), K_RGB, 'h3F, "f1_x520_edge");
        sb_push(pix(1, 521, 2), K_RGB, 0, "f1_x521");
        // frame 2: colour bars
        sb_push(pix(2, 0, 0), K_RGB, 0, "bars_x0");
        sb_push(pix(2, 127, 0), K_RGB, 0, "bars_x127");
        sb_push(pix(2, 128, 0), K_RGB, 'h30, "bars_x128");
        sb_push(pix(2, 256, 0), K_RGB, 'h0C, "bars_x256");
        sb_push(pix(2, 384, 0), K_RGB, 'h3C, "bars_x384");
        sb_push(pix(2, 512, 0), K_RGB, 'h03, "bars_x512");
        sb_push(pix(2, 639, 0), K_RGB, 'h03, "bars_x639");
        sb_push(pix(2, 640, 0), K_RGB, 0, "bars_x640_blank");
        // frame 3: full-screen XOR, frame_cnt=3
        sb_push(pix(3, 13, 0), K_RGB, 'h12, "xorfull_13_0");
        sb_push(pix(3, 300, 2), K_RGB, 'h20, "xorfull_300_2");
        sb_push(pix(3, 100, 3), K_RGB, 'h24, "xorfull_100_3");
        // frame 4: XOR in circle r=100, frame_cnt=0
        sb_push(pix(4, 100, 2), K_RGB, 0, "xorcirc_out_100");
        sb_push(pix(4, 320, 2), K_RGB, 'h04, "xorcirc_centre");
        sb_push(pix(4, 400, 2), K_RGB, 'h1A, "xorcirc_400");
        sb_push(pix(4, 420, 2), K_RGB, 'h28, "xorcirc_edge_420");
        sb_push(pix(4, 421, 2), K_RGB, 0, "xorcirc_out_421");
        // frame 5: radius 450 lights the whole active area
        sb_push(pix(5, 0, 0), K_RGB, 'h3F, "r450_origin");
        sb_push(pix(5, 639, 3), K_RGB, 'h3F, "r450_last_px");
        sb_push(pix(5, 640, 3), K_RGB, 0, "r450_x640_blank");
        // pause across three ticks, then resume
        sb_push(4 * FRAME + TICK + 1, K_CNT, 0, "pause_tick1");
        sb_push(5 * FRAME + TICK, K_TCK, 1, "pause_tick_pulses");
        sb_push(5 * FRAME + TICK + 1, K_CNT, 0, "pause_tick2");
        sb_push(6 * FRAME + TICK + 1, K_CNT, 0, "pause_tick3");
        sb_push(7 * FRAME + TICK + 1, K_CNT, 1, "resume_tick");
        sb_push(pix(8, 100, 2), K_RGB, 'h3F, "f8_lit_before_reset");
    endtask

    task automatic push_session2();
        sb_push(2, K_RGB, 0, "rst2_origin_dark");
        sb_push(10, K_CNT, 0, "rst2_fcnt");
        sb_push(657, K_HS, 1, "rst2_hs_before_fall");
        sb_push(658, K_HS, 0, "rst2_hs_fall");
        sb_push(pix(0, 320, 2), K_RGB, 'h3F, "rst2_centre");
        sb_push(TICK, K_TCK, 1, "rst2_tick");
    endtask

    // Watchdog
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Stimulus
    initial begin
        push_session1();
        repeat (3) @(posedge clk);
        #2;
        check("rst_hsync", 32'(hsync), 1);
        check("rst_vsync", 32'(vsync), 1);
        check("rst_rgb", 32'({r, g, b}), 0);
        check("rst_tick", 32'(frame_tick), 0);
        check("rst_fcnt", 32'(frame_cnt), 0);
        @(negedge clk);
        rst_n = 1'b1;

        wait_cyc(cnt(1, 10, 1));
        mode = 2'd3;
        wait_cyc(cnt(2, 0, 3));
        mode = 2'd2;
        wait_cyc(cnt(3, 0, 3));
        mode   = 2'd1;
        radius = 9'd100;
        wait_cyc(cnt(4, 0, 3));
        mode   = 2'd0;
        radius = 9'd450;
        pause  = 1'b1;
        wait_cyc(cnt(6, 0, 5) + 400);
        pause = 1'b0;

        // asynchronous reset in the middle of a visible line
        wait_cyc(cnt(8, 300, 2));
        #2;
        check("sb_drained_s1", 32'(sb.size()), 0);
        rst_n = 1'b0;
        #1;
        check("async_hsync", 32'(hsync), 1);
        check("async_vsync", 32'(vsync), 1);
        check("async_rgb", 32'({r, g, b}), 0);
        check("async_tick", 32'(frame_tick), 0);
        check("async_fcnt", 32'(frame_cnt), 0);
        repeat (3) @(posedge clk);
        push_session2();
        @(negedge clk);
        rst_n = 1'b1;
        wait_cyc(TICK + 100);
        check("sb_drained_s2", 32'(sb.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
